// File: rtl/up_timer_mm_ss_if.sv
// Signal bundle between the elapsed-time counter and its controller/display path.
// master drives commands and the limit; slave is the counter.
interface up_timer_mm_ss_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] limit_min;
  logic [7:0] limit_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       rollover;

  modport master (
    output tick, start, stop, clear, limit_min, limit_sec,
    input  min_bcd, sec_bcd, running, done, rollover
  );

  modport slave (
    input  tick, start, stop, clear, limit_min, limit_sec,
    output min_bcd, sec_bcd, running, done, rollover
  );
endinterface

// File: rtl/up_timer_mm_ss.sv
// Elapsed irrigation time counter, BCD mm:ss (00:00..99:59), advanced by a
// prescaled tick, with a programmable limit that latches a sticky done.
module up_timer_mm_ss #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  up_timer_mm_ss_if.slave bus
);

  localparam int unsigned     PS_W    = $clog2(PRESCALE) + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [PS_W-1:0] ps, ps_nx;
  logic [15:0]     tm, tm_nx;          // {min tens, min units, sec tens, sec units}
  logic            running_q, done_q, rollover_q, rollover_nx;

  logic [3:0]      inc_mt, inc_mu, inc_st, inc_su;
  logic            wrap;
  logic [15:0]     inc_tm;
  logic [15:0]     limit;
  logic            limit_ok;
  logic            limit_hit;

  // One BCD second increment with ripple carry through all four digits.
  always_comb begin
    inc_mt = tm[15:12];
    inc_mu = tm[11:8];
    inc_st = tm[7:4];
    inc_su = tm[3:0];
    wrap   = 1'b0;
    if (tm[3:0] != 4'd9) begin
      inc_su = tm[3:0] + 4'd1;
    end else begin
      inc_su = 4'd0;
      if (tm[7:4] != 4'd5) begin
        inc_st = tm[7:4] + 4'd1;
      end else begin
        inc_st = 4'd0;
        if (tm[11:8] != 4'd9) begin
          inc_mu = tm[11:8] + 4'd1;
        end else begin
          inc_mu = 4'd0;
          if (tm[15:12] != 4'd9) begin
            inc_mt = tm[15:12] + 4'd1;
          end else begin
            inc_mt = 4'd0;
            wrap   = 1'b1;
          end
        end
      end
    end
  end

  assign inc_tm = {inc_mt, inc_mu, inc_st, inc_su};

  // A malformed BCD limit or 00:00 can never match, so the counter free-runs.
  assign limit    = {bus.limit_min, bus.limit_sec};
  assign limit_ok = (limit[15:12] <= 4'd9) && (limit[11:8] <= 4'd9) &&
                    (limit[7:4]   <= 4'd5) && (limit[3:0]  <= 4'd9) &&
                    (limit != 16'h0000);
  assign limit_hit = limit_ok && (inc_tm == limit);

  // Next state; command priority is clear, then stop, then start, then tick.
  always_comb begin
    state_nx    = state;
    ps_nx       = ps;
    tm_nx       = tm;
    rollover_nx = 1'b0;
    if (bus.clear) begin
      state_nx = IDLE;
      ps_nx    = '0;
      tm_nx    = 16'h0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.stop) state_nx = RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state_nx = HOLD;
          end else if (bus.tick) begin
            if (ps == PS_LAST) begin
              ps_nx       = '0;
              tm_nx       = inc_tm;
              rollover_nx = wrap;
              if (limit_hit) state_nx = DONE;
            end else begin
              ps_nx = ps + PS_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.start && !bus.stop) state_nx = RUN;
        end
        DONE: begin
          state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ps         <= '0;
      tm         <= 16'h0000;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state      <= state_nx;
      ps         <= ps_nx;
      tm         <= tm_nx;
      running_q  <= (state_nx == RUN);
      done_q     <= (state_nx == DONE);
      rollover_q <= rollover_nx;
    end
  end

  assign bus.min_bcd  = tm[15:8];
  assign bus.sec_bcd  = tm[7:0];
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_up_timer_mm_ss.sv
// Bench for up_timer_mm_ss: two instances (PRESCALE 1 and 4) share stimulus;
// a seconds-based reference model feeds a scoreboard checked every cycle.
module tb_up_timer_mm_ss;

  logic clock = 1'b0;
  logic reset_n;
  logic tick, start, stop, clear;
  logic [7:0] limit_min, limit_sec;

  always #5 clock = ~clock;

  up_timer_mm_ss_if if1 ();
  up_timer_mm_ss_if if4 ();

  assign if1.tick = tick;   assign if4.tick = tick;
  assign if1.start = start; assign if4.start = start;
  assign if1.stop = stop;   assign if4.stop = stop;
  assign if1.clear = clear; assign if4.clear = clear;
  assign if1.limit_min = limit_min; assign if4.limit_min = limit_min;
  assign if1.limit_sec = limit_sec; assign if4.limit_sec = limit_sec;

  up_timer_mm_ss #(.PRESCALE(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(if1));
  up_timer_mm_ss #(.PRESCALE(4)) dut4 (.clock(clock), .reset_n(reset_n), .bus(if4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed time held as plain seconds 0..5999.
  int unsigned presc [2] = '{1, 4};
  int unsigned m_t   [2];
  int unsigned m_ps  [2];
  int          m_st  [2];   // 0 idle, 1 run, 2 hold, 3 done
  bit          m_roll[2];

  function automatic logic [15:0] to_bcd(input int unsigned v);
    int unsigned m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit lim_valid(output int unsigned secs);
    int unsigned mt, mu, st, su;
    mt = int'(limit_min[7:4]); mu = int'(limit_min[3:0]);
    st = int'(limit_sec[7:4]); su = int'(limit_sec[3:0]);
    secs = (mt * 10 + mu) * 60 + st * 10 + su;
    return (mt <= 9) && (mu <= 9) && (st <= 5) && (su <= 9) && (secs != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_ps[i] = 0; m_st[i] = 0; m_roll[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit tk, input bit sa, input bit sp, input bit cl);
    int unsigned lim;
    bit ok;
    ok = lim_valid(lim);
    m_roll[i] = 1'b0;
    if (cl) begin
      m_st[i] = 0; m_t[i] = 0; m_ps[i] = 0;
    end else begin
      case (m_st[i])
        0, 2: if (sa && !sp) m_st[i] = 1;
        1: begin
          if (sp) m_st[i] = 2;
          else if (tk) begin
            if (m_ps[i] == presc[i] - 1) begin
              m_ps[i] = 0;
              m_t[i]++;
              if (m_t[i] == 6000) begin m_t[i] = 0; m_roll[i] = 1'b1; end
              if (ok && m_t[i] == lim) m_st[i] = 3;
            end else m_ps[i]++;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [18:0] model_out(input int i);
    return {to_bcd(m_t[i]), m_st[i] == 1, m_st[i] == 3, m_roll[i]};
  endfunction

  typedef struct { logic [18:0] e1; logic [18:0] e4; } exp_t;
  exp_t sb[$];

  // Scoreboard drain: compare each registered result just after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("p1", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.done, if1.rollover}), 32'(e.e1));
        check("p4", 32'({if4.min_bcd, if4.sec_bcd, if4.running, if4.done, if4.rollover}), 32'(e.e4));
      end
    end
  end

  task automatic cyc(input bit tk, input bit sa, input bit sp, input bit cl);
    exp_t e;
    @(negedge clock);
    tick = tk; start = sa; stop = sp; clear = cl;
    model_step(0, tk, sa, sp, cl);
    model_step(1, tk, sa, sp, cl);
    e.e1 = model_out(0);
    e.e4 = model_out(1);
    sb.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset_n = 1'b0;
    {tick, start, stop, clear} = 4'b0;
    limit_min = 8'h00; limit_sec = 8'h00;
    model_reset();
    #23;
    check("reset1", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.done, if1.rollover}), 32'd0);
    check("reset4", 32'({if4.min_bcd, if4.sec_bcd, if4.running, if4.done, if4.rollover}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // 60 seconds, no limit
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(60);
    settle();
    check("t1_time", 32'({if1.min_bcd, if1.sec_bcd}), 32'h0100);
    check("t1_flags", 32'({if1.running, if1.done, if1.rollover}), 32'b100);

    // run up to 99:58, then across the wrap
    ticks(5998 - 60);
    settle();
    check("t2_9958", 32'({if1.min_bcd, if1.sec_bcd}), 32'h9958);
    ticks(1);
    @(posedge clock); #2;
    check("t2_9959", 32'({if1.min_bcd, if1.sec_bcd, if1.rollover}), 32'({16'h9959, 1'b0}));
    ticks(1);
    @(posedge clock); #2;
    check("t2_wrap", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.rollover}), 32'({16'h0000, 2'b11}));
    settle();
    check("t2_pulse", 32'(if1.rollover), 32'd0);

    // limit 00:05 -> sticky done
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    limit_sec = 8'h05;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    settle();
    check("t3_done", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.done}), 32'({16'h0005, 2'b01}));
    ticks(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    settle();
    check("t3_frozen", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.done}), 32'({16'h0005, 2'b01}));

    // prescaler retained across HOLD
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    limit_sec = 8'h00;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    settle();
    check("t4_hold", 32'({if4.min_bcd, if4.sec_bcd, if4.running}), 32'({16'h0000, 1'b0}));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    settle();
    check("t4_resume", 32'({if4.min_bcd, if4.sec_bcd, if4.running}), 32'({16'h0001, 1'b1}));

    // same-cycle command collisions
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("t5_start_tick", 32'({if1.min_bcd, if1.sec_bcd, if1.running}), 32'({16'h0000, 1'b1}));
    ticks(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    check("t5_stop_tick", 32'({if1.min_bcd, if1.sec_bcd, if1.running}), 32'({16'h0001, 1'b0}));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check("t5_clear_start", 32'({if1.min_bcd, if1.sec_bcd, if1.running}), 32'({16'h0000, 1'b0}));

    // malformed limits never match
    limit_sec = 8'h0A;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(12);
    limit_sec = 8'h60;
    ticks(70);
    settle();
    check("t7_invalid", 32'({if1.min_bcd, if1.sec_bcd, if1.done}), 32'({16'h0122, 1'b0}));

    // async reset mid-count at 12:34
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    limit_sec = 8'h00;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(754);
    settle();
    check("t6_1234", 32'({if1.min_bcd, if1.sec_bcd, if1.running}), 32'({16'h1234, 1'b1}));
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_async1", 32'({if1.min_bcd, if1.sec_bcd, if1.running, if1.done, if1.rollover}), 32'd0);
    check("t6_async4", 32'({if4.min_bcd, if4.sec_bcd, if4.running, if4.done, if4.rollover}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    settle();
    check("t6_restart", 32'({if1.min_bcd, if1.sec_bcd, if1.running}), 32'({16'h0001, 1'b1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
